// File: rtl/symbol_encoder_if.sv
// Stream bundle between the bit-plane transform, the symbol encoder and the bit packer.
// master drives base/plane words and the packer ready; slave is the encoder.
interface symbol_encoder_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned LOG_DATA_W = $clog2(DATA_W)
) ();
    logic [DATA_W-1:0]     base;
    logic                  base_vld;
    logic                  base_rdy;
    logic [BLOCK_SIZE-2:0] dbx;
    logic [BLOCK_SIZE-2:0] dbp;
    logic                  plane_vld;
    logic                  plane_rdy;
    logic [DATA_W-1:0]     data;
    logic [LOG_DATA_W:0]   len;
    logic                  vld;
    logic                  rdy;

    modport master (
        output base, base_vld, dbx, dbp, plane_vld, rdy,
        input  base_rdy, plane_rdy, data, len, vld
    );

    modport slave (
        input  base, base_vld, dbx, dbp, plane_vld, rdy,
        output base_rdy, plane_rdy, data, len, vld
    );
endinterface

// File: rtl/symbol_encoder.sv
// EBPC symbol encoder: base word plus DATA_W+1 bit planes per block into MSB-aligned symbols.
// Optional block bit-count statistics are enabled with the EBPC_ENC_STATS_EN macro.
module symbol_encoder #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned LOG_DATA_W = $clog2(DATA_W)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    symbol_encoder_if.slave bus,
    output logic            idle_o
`ifdef EBPC_ENC_STATS_EN
    ,
    output logic [2*DATA_W-1:0] blk_bits_o,
    output logic                blk_bits_vld_o
`endif
);
    localparam int unsigned PW    = BLOCK_SIZE - 1;
    localparam int unsigned IDX_W = $clog2(BLOCK_SIZE - 1);
    localparam int unsigned LEN_W = LOG_DATA_W + 1;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StEnc, StFlush} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    plane_cnt_q;
    logic [LEN_W-1:0]    zero_cnt_q;
    logic [DATA_W-1:0]   data_q;
    logic [LEN_W-1:0]    len_q;
    logic                vld_q;

    logic                slot_free, plane_zero;
    logic                base_rdy, plane_rdy, base_acc, plane_acc;
    logic                emit;
    logic [DATA_W-1:0]   emit_data, plane_sym, run_sym;
    logic [LEN_W-1:0]    emit_len, plane_len, run_len;
    logic [IDX_W-1:0]    low_idx;
    logic [LOG_DATA_W-1:0] run_m2;
`ifdef EBPC_ENC_STATS_EN
    logic                emit_first, emit_last, last_q;
    logic [2*DATA_W-1:0] acc_q;
`endif

    // Plane symbol, in code priority order
    always_comb begin
        low_idx = '0;
        for (int i = int'(PW) - 1; i >= 0; i--) begin
            if (bus.dbx[i]) low_idx = IDX_W'(i);
        end
        plane_sym = '0;
        if (&bus.dbx) begin
            plane_len = LEN_W'(5);
        end else if (bus.dbp == '0) begin
            plane_sym[DATA_W-1 -: 5] = 5'b00001;
            plane_len                = LEN_W'(5);
        end else if ($countones(bus.dbx) == 2 && (bus.dbx & (bus.dbx >> 1)) != '0) begin
            plane_sym[DATA_W-1 -: 5]     = 5'b00010;
            plane_sym[DATA_W-6 -: IDX_W] = low_idx;
            plane_len                    = LEN_W'(5 + IDX_W);
        end else if ($countones(bus.dbx) == 1) begin
            plane_sym[DATA_W-1 -: 5]     = 5'b00011;
            plane_sym[DATA_W-6 -: IDX_W] = low_idx;
            plane_len                    = LEN_W'(5 + IDX_W);
        end else begin
            plane_sym[DATA_W-1]      = 1'b1;
            plane_sym[DATA_W-2 -: PW] = bus.dbx;
            plane_len                = LEN_W'(BLOCK_SIZE);
        end
    end

    always_comb begin
        run_m2  = LOG_DATA_W'(zero_cnt_q - LEN_W'(2));
        run_sym = '0;
        if (zero_cnt_q == LEN_W'(1)) begin
            run_sym[DATA_W-1 -: 2] = 2'b01;
            run_len                = LEN_W'(2);
        end else begin
            run_sym[DATA_W-1 -: 3]          = 3'b001;
            run_sym[DATA_W-4 -: LOG_DATA_W] = run_m2;
            run_len                         = LEN_W'(3 + LOG_DATA_W);
        end
    end

    // Handshake and emit decision
    always_comb begin
        slot_free  = !vld_q || bus.rdy;
        plane_zero = (bus.dbx == '0);
        base_rdy   = 1'b0;
        plane_rdy  = 1'b0;
        emit       = 1'b0;
        emit_data  = plane_sym;
        emit_len   = plane_len;
`ifdef EBPC_ENC_STATS_EN
        emit_first = 1'b0;
        emit_last  = 1'b0;
`endif
        if (!clr_i) begin
            unique case (state_q)
                StIdle: begin
                    base_rdy = slot_free;
                    if (bus.base_vld && slot_free) begin
                        emit      = 1'b1;
                        emit_data = bus.base;
                        emit_len  = LEN_W'(DATA_W);
`ifdef EBPC_ENC_STATS_EN
                        emit_first = 1'b1;
`endif
                    end
                end
                StEnc: begin
                    if (plane_zero) begin
                        plane_rdy = 1'b1;
                    end else if (zero_cnt_q != '0) begin
                        // Pending run goes out first; the plane waits a cycle
                        if (bus.plane_vld && slot_free) begin
                            emit      = 1'b1;
                            emit_data = run_sym;
                            emit_len  = run_len;
                        end
                    end else begin
                        plane_rdy = slot_free;
                        if (bus.plane_vld && slot_free) begin
                            emit = 1'b1;
`ifdef EBPC_ENC_STATS_EN
                            emit_last = (plane_cnt_q == CNT_W'(DATA_W));
`endif
                        end
                    end
                end
                StFlush: begin
                    if (slot_free) begin
                        emit      = 1'b1;
                        emit_data = run_sym;
                        emit_len  = run_len;
`ifdef EBPC_ENC_STATS_EN
                        emit_last = 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
        base_acc  = bus.base_vld && base_rdy;
        plane_acc = bus.plane_vld && plane_rdy;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q     <= StIdle;
            plane_cnt_q <= '0;
            zero_cnt_q  <= '0;
            vld_q       <= 1'b0;
            data_q      <= '0;
            len_q       <= '0;
`ifdef EBPC_ENC_STATS_EN
            last_q      <= 1'b0;
            acc_q       <= '0;
`endif
        end else begin
            if (emit) begin
                data_q <= emit_data;
                len_q  <= emit_len;
                vld_q  <= 1'b1;
`ifdef EBPC_ENC_STATS_EN
                last_q <= emit_last;
                acc_q  <= emit_first ? (2*DATA_W)'(emit_len)
                                     : acc_q + (2*DATA_W)'(emit_len);
`endif
            end else if (bus.rdy) begin
                vld_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (base_acc) begin
                        plane_cnt_q <= '0;
                        state_q     <= StEnc;
                    end
                end
                StEnc: begin
                    if (plane_acc) begin
                        plane_cnt_q <= plane_cnt_q + CNT_W'(1);
                        if (plane_zero) zero_cnt_q <= zero_cnt_q + LEN_W'(1);
                        if (plane_cnt_q == CNT_W'(DATA_W)) begin
                            state_q <= plane_zero ? StFlush : StIdle;
                        end
                    end else if (emit) begin
                        zero_cnt_q <= '0;
                    end
                end
                StFlush: begin
                    if (emit) begin
                        zero_cnt_q <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.base_rdy  = base_rdy;
    assign bus.plane_rdy = plane_rdy;
    assign bus.data      = data_q;
    assign bus.len       = len_q;
    assign bus.vld       = vld_q;
    assign idle_o        = (state_q == StIdle) && !vld_q;
`ifdef EBPC_ENC_STATS_EN
    assign blk_bits_o     = acc_q;
    assign blk_bits_vld_o = vld_q && bus.rdy && last_q;
`endif
endmodule

// File: tb/tb_symbol_encoder.sv
// Directed bench for symbol_encoder (DATA_W=8, BLOCK_SIZE=8); symbols are logged as {data, len}.
module tb_symbol_encoder;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic clr = 1'b0;
    logic idle;
    int   errors = 0;
    int   checks = 0;
    logic [11:0] got_q[$];

    always #5 clk = ~clk;

    symbol_encoder_if #(.DATA_W(8), .BLOCK_SIZE(8), .LOG_DATA_W(3)) bus ();

`ifdef EBPC_ENC_STATS_EN
    logic [15:0] blk_bits;
    logic        blk_bits_vld;
    int          pulse_cnt = 0;
    logic [15:0] pulse_val = '0;
    always @(negedge clk) if (blk_bits_vld) begin
        pulse_cnt++;
        pulse_val = blk_bits;
    end
`endif

    symbol_encoder #(.DATA_W(8), .BLOCK_SIZE(8), .LOG_DATA_W(3)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .clr_i (clr),
        .bus   (bus),
        .idle_o(idle)
`ifdef EBPC_ENC_STATS_EN
        ,
        .blk_bits_o    (blk_bits),
        .blk_bits_vld_o(blk_bits_vld)
`endif
    );

    // Handshake happens on the following posedge
    always @(negedge clk) if (bus.vld && bus.rdy) got_q.push_back({bus.data, bus.len});

    task automatic send_base(input logic [7:0] b);
        int n = 0;
        bus.base     = b;
        bus.base_vld = 1'b1;
        @(negedge clk);
        while (!bus.base_rdy && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.base_vld = 1'b0;
    endtask

    task automatic send_plane(input logic [6:0] x, input logic [6:0] p, output int stall);
        stall         = 0;
        bus.dbx       = x;
        bus.dbp       = p;
        bus.plane_vld = 1'b1;
        @(negedge clk);
        while (!bus.plane_rdy && stall < 50) begin
            stall++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.plane_vld = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = idle;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.plane_vld = 1'b1;
        @(negedge clk);
        checks += 6;
        if (bus.vld !== 1'b0) begin errors++; $display("FAIL reset vld: got %b want 0", bus.vld); end
        if (bus.data !== 8'h00) begin errors++; $display("FAIL reset data: got %h want 00", bus.data); end
        if (bus.len !== 4'd0) begin errors++; $display("FAIL reset len: got %0d want 0", bus.len); end
        if (idle !== 1'b1) begin errors++; $display("FAIL reset idle: got %b want 1", idle); end
        if (bus.base_rdy !== 1'b1) begin errors++; $display("FAIL reset base_rdy: got %b want 1", bus.base_rdy); end
        if (bus.plane_rdy !== 1'b0) begin errors++; $display("FAIL reset plane_rdy: got %b want 0", bus.plane_rdy); end
        @(posedge clk); #1;
        bus.plane_vld = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_all_zero();
        logic [11:0] exp[$];
        logic ok;
        int   st;
        exp = '{12'h008, 12'h3C6};
        got_q.delete();
        send_base(8'h00);
        @(negedge clk);
        checks++;
        if (idle !== 1'b0) begin errors++; $display("FAIL all_zero busy idle: got %b want 0", idle); end
        @(posedge clk); #1;
        repeat (9) send_plane(7'h00, 7'h00, st);
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL all_zero idle: got 0 want 1"); end
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL all_zero count: got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++; $display("FAIL all_zero sym%0d: got %h want %h", i, got_q[i], exp[i]);
            end
        end
`ifdef EBPC_ENC_STATS_EN
        checks += 2;
        if (pulse_cnt != 1) begin errors++; $display("FAIL stats pulses: got %0d want 1", pulse_cnt); end
        if (pulse_val !== 16'd14) begin errors++; $display("FAIL stats bits: got %0d want 14", pulse_val); end
`endif
    endtask

    task automatic test_mixed();
        logic [11:0] exp[$];
        logic [6:0]  xs[9];
        logic [6:0]  ps[9];
        logic ok;
        int   st;
        exp = '{12'hA58, 12'h1A8, 12'h128, 12'h005, 12'h085, 12'hD58, 12'h286};
        xs  = '{7'h04, 7'h0C, 7'h7F, 7'h55, 7'h55, 7'h00, 7'h00, 7'h00, 7'h00};
        ps  = '{7'h04, 7'h0C, 7'h01, 7'h00, 7'h2A, 7'h00, 7'h00, 7'h00, 7'h00};
        got_q.delete();
        send_base(8'hA5);
        for (int i = 0; i < 9; i++) send_plane(xs[i], ps[i], st);
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL mixed idle: got 0 want 1"); end
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL mixed count: got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++; $display("FAIL mixed sym%0d: got %h want %h", i, got_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_single_zero();
        logic [11:0] exp[$];
        logic [6:0]  xs[9];
        logic [6:0]  ps[9];
        int   stalls[9];
        logic ok;
        exp = '{12'h118, 12'h1A8, 12'h402, 12'h188, 12'h108, 12'h158, 12'h1E8, 12'h005,
                12'h085, 12'h858};
        xs  = '{7'h04, 7'h00, 7'h01, 7'h03, 7'h60, 7'h40, 7'h7F, 7'h05, 7'h05};
        ps  = '{7'h04, 7'h00, 7'h01, 7'h03, 7'h60, 7'h40, 7'h7F, 7'h00, 7'h05};
        got_q.delete();
        send_base(8'h11);
        for (int i = 0; i < 9; i++) send_plane(xs[i], ps[i], stalls[i]);
        wait_idle(ok);
        checks += 4;
        if (!ok) begin errors++; $display("FAIL single_zero idle: got 0 want 1"); end
        if (stalls[2] != 1) begin errors++; $display("FAIL single_zero hold: got %0d want 1", stalls[2]); end
        if (stalls[1] != 0) begin errors++; $display("FAIL single_zero zero_hold: got %0d want 0", stalls[1]); end
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL single_zero count: got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++; $display("FAIL single_zero sym%0d: got %h want %h", i, got_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [11:0] exp[$];
        logic ok;
        int   st;
        int   zst = 0;
        exp = '{12'h228, 12'h198, 12'h246, 12'h1B8, 12'h286};
        got_q.delete();
        send_base(8'h22);
        send_plane(7'h02, 7'h02, st);
        bus.rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    send_plane(7'h00, 7'h00, st);
                    zst += st;
                end
                send_plane(7'h08, 7'h08, st);
                for (int i = 0; i < 4; i++) send_plane(7'h00, 7'h00, st);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checks++;
                    if (bus.vld !== 1'b1 || bus.data !== 8'h19 || bus.len !== 4'd8) begin
                        errors++;
                        $display("FAIL stall_hold c%0d: got vld=%b %h/%0d want 1 19/8",
                                 i, bus.vld, bus.data, bus.len);
                    end
                end
                @(posedge clk); #1;
                bus.rdy = 1'b1;
            end
        join
        wait_idle(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL stall idle: got 0 want 1"); end
        if (zst != 0) begin errors++; $display("FAIL stall zero_accept: got %0d wait cycles want 0", zst); end
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL stall count: got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++; $display("FAIL stall sym%0d: got %h want %h", i, got_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_clear();
        logic [11:0] exp[$];
        logic ok;
        int   st;
        exp = '{12'h338, 12'h1A8, 12'h448, 12'h188, 12'h386};
        got_q.delete();
        send_base(8'h33);
        send_plane(7'h04, 7'h04, st);
        send_plane(7'h0C, 7'h0C, st);
        bus.rdy = 1'b0;
        send_plane(7'h00, 7'h00, st);
        send_plane(7'h00, 7'h00, st);
        clr           = 1'b1;
        bus.dbx       = 7'h00;
        bus.plane_vld = 1'b1;
        @(negedge clk);
        checks += 3;
        if (bus.plane_rdy !== 1'b0) begin errors++; $display("FAIL clr plane_rdy: got %b want 0", bus.plane_rdy); end
        if (bus.base_rdy !== 1'b0) begin errors++; $display("FAIL clr base_rdy: got %b want 0", bus.base_rdy); end
        if (bus.vld !== 1'b1) begin errors++; $display("FAIL clr pending: got %b want 1", bus.vld); end
        @(posedge clk); #1;
        clr           = 1'b0;
        bus.plane_vld = 1'b0;
        bus.rdy       = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.vld !== 1'b0) begin errors++; $display("FAIL clr vld: got %b want 0", bus.vld); end
        if (idle !== 1'b1) begin errors++; $display("FAIL clr idle: got %b want 1", idle); end
        if (bus.data !== 8'h00) begin errors++; $display("FAIL clr data: got %h want 00", bus.data); end
        if (bus.len !== 4'd0) begin errors++; $display("FAIL clr len: got %0d want 0", bus.len); end
        @(posedge clk); #1;
        send_base(8'h44);
        send_plane(7'h01, 7'h01, st);
        repeat (8) send_plane(7'h00, 7'h00, st);
        wait_idle(ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL clr_next idle: got 0 want 1"); end
        if (got_q.size() != exp.size()) begin
            errors++; $display("FAIL clr_next count: got %0d want %0d", got_q.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp[i]) begin
                errors++; $display("FAIL clr_next sym%0d: got %h want %h", i, got_q[i], exp[i]);
            end
        end
    endtask

    initial begin
        bus.base      = '0;
        bus.base_vld  = 1'b0;
        bus.dbx       = '0;
        bus.dbp       = '0;
        bus.plane_vld = 1'b0;
        bus.rdy       = 1'b1;
        test_reset();
        test_all_zero();
        test_mixed();
        test_single_zero();
        test_back_pressure();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
